// File: rtl/keccak_padder_pkg.sv
// Shared constants and types for the Keccak message padder.
//   IN_BUF_SIZE  width of one message / buffer word in bits
//   RATE_BITS    Keccak rate (one absorbed block) in bits
//   RATE_BYTES   rate in bytes
//   PAD_FIRST    first byte of pad10*1 padding
//   PAD_LAST     bit ORed into the last byte of the rate
//   pad_state_t  padder FSM states
package keccak_padder_pkg;

    localparam int         IN_BUF_SIZE = 64;
    localparam int         RATE_BITS   = 1024;
    localparam int         RATE_BYTES  = RATE_BITS / 8;
    localparam logic [7:0] PAD_FIRST   = 8'h01;
    localparam logic [7:0] PAD_LAST    = 8'h80;

    typedef enum logic [2:0] {
        S_DATA,
        S_PADW,
        S_FILL,
        S_LAST,
        S_OUT
    } pad_state_t;

endpackage

// File: rtl/keccak_pad_merge.sv
// Combinational pad merge for one word.
//   word      in   WIDTH  source word (message data, or zero for pad words)
//   b         in   BCW    number of message bytes kept when first_en is set
//   first_en  in   1      zero bytes above b and place PAD_FIRST at byte b
//   last_en   in   1      OR PAD_LAST into the top byte (last byte of the rate)
//   padded    out  WIDTH  resulting word
module keccak_pad_merge
    import keccak_padder_pkg::*;
#(
    parameter  int WIDTH = IN_BUF_SIZE,
    localparam int NB    = WIDTH / 8,
    localparam int BCW   = $clog2(NB) + 1
) (
    input  logic [WIDTH-1:0] word,
    input  logic [BCW-1:0]   b,
    input  logic             first_en,
    input  logic             last_en,
    output logic [WIDTH-1:0] padded
);

    always_comb begin
        padded = word;
        for (int k = 0; k < NB; k++) begin
            if (first_en) begin
                if (BCW'(k) == b) begin
                    padded[8*k +: 8] = PAD_FIRST;
                end else if (BCW'(k) > b) begin
                    padded[8*k +: 8] = 8'h00;
                end
            end
        end
        // Applied after the first-byte step so b==NB-1 yields 0x81.
        if (last_en) begin
            padded[WIDTH-1 -: 8] = padded[WIDTH-1 -: 8] | PAD_LAST;
        end
    end

endmodule

// File: rtl/keccak_padder.sv
// Message-side feeder for keccak_buffer with pad10*1 padding.
//   Clock, Reset_n           clock and synchronous active-low reset
//   In_data/In_valid/In_last message words (little-endian bytes), In_bytes on last
//   In_ready                 word accepted when In_valid & In_ready
//   Din_buffer_in(_valid)    registered padded words, one-cycle strobe each
//   Din_buffer_full, Ready   block handshake with keccak_buffer / permutation
//   Last_block               final block of the message sits in the buffer
//   Dout_buffer_out_valid    digest stream; a new message waits for it to drain
//
// state  | meaning
// S_DATA | passing message words; last word gets padded in place
// S_PADW | message filled its last word exactly; a 0x01 pad word is owed
// S_FILL | emitting zero words up to the end of the block
// S_LAST | final block written, waiting for the permutation to take it
// S_OUT  | waiting for the digest stream to rise and fall
module keccak_padder #(
    parameter  int IN_BUF_SIZE = keccak_padder_pkg::IN_BUF_SIZE,
    parameter  int RATE_BITS   = keccak_padder_pkg::RATE_BITS,
    localparam int BCW         = $clog2(IN_BUF_SIZE / 8) + 1
) (
    input  logic                   Clock,
    input  logic                   Reset_n,
    input  logic [IN_BUF_SIZE-1:0] In_data,
    input  logic                   In_valid,
    input  logic                   In_last,
    input  logic [BCW-1:0]         In_bytes,
    output logic                   In_ready,
    output logic [IN_BUF_SIZE-1:0] Din_buffer_in,
    output logic                   Din_buffer_in_valid,
    input  logic                   Din_buffer_full,
    input  logic                   Ready,
    output logic                   Last_block,
    input  logic                   Dout_buffer_out_valid
);
    import keccak_padder_pkg::*;

    localparam int N   = IN_BUF_SIZE / 8;
    localparam int W   = RATE_BITS / IN_BUF_SIZE;
    localparam int WCW = (W > 1) ? $clog2(W) : 1;

    pad_state_t             state;
    pad_state_t             next_after;
    logic [WCW-1:0]         word_cnt;
    logic                   blk_wait;
    logic                   seen_dout;
    logic [BCW-1:0]         b_clamp;
    logic                   at_last_word;
    logic                   emit;
    logic [IN_BUF_SIZE-1:0] m_word;
    logic [BCW-1:0]         m_b;
    logic                   m_first;
    logic                   m_last;
    logic [IN_BUF_SIZE-1:0] padded;

    assign In_ready     = (state == S_DATA) & ~blk_wait & Reset_n;
    assign b_clamp      = (In_bytes > BCW'(N)) ? BCW'(N) : In_bytes;
    assign at_last_word = (word_cnt == WCW'(W - 1));

    always_comb begin
        emit       = 1'b0;
        m_word     = '0;
        m_b        = '0;
        m_first    = 1'b0;
        m_last     = 1'b0;
        next_after = state;
        case (state)
            S_DATA: begin
                emit   = In_valid & In_ready;
                m_word = In_data;
                if (In_last) begin
                    m_b = b_clamp;
                    if (b_clamp < BCW'(N)) begin
                        m_first    = 1'b1;
                        m_last     = at_last_word;
                        next_after = at_last_word ? S_LAST : S_FILL;
                    end else begin
                        // Full last word: padding still owed in a following word.
                        next_after = S_PADW;
                    end
                end
            end
            S_PADW: begin
                emit       = ~blk_wait;
                m_first    = 1'b1;
                m_last     = at_last_word;
                next_after = at_last_word ? S_LAST : S_FILL;
            end
            S_FILL: begin
                emit       = ~blk_wait;
                m_last     = at_last_word;
                next_after = at_last_word ? S_LAST : S_FILL;
            end
            default: ;
        endcase
    end

    keccak_pad_merge #(.WIDTH(IN_BUF_SIZE)) u_merge (
        .word     (m_word),
        .b        (m_b),
        .first_en (m_first),
        .last_en  (m_last),
        .padded   (padded)
    );

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state               <= S_DATA;
            word_cnt            <= '0;
            blk_wait            <= 1'b0;
            seen_dout           <= 1'b0;
            Din_buffer_in       <= '0;
            Din_buffer_in_valid <= 1'b0;
            Last_block          <= 1'b0;
        end else begin
            Din_buffer_in_valid <= 1'b0;
            if (emit) begin
                Din_buffer_in       <= padded;
                Din_buffer_in_valid <= 1'b1;
                state               <= next_after;
                if (at_last_word) begin
                    word_cnt <= '0;
                    blk_wait <= 1'b1;
                end else begin
                    word_cnt <= word_cnt + WCW'(1);
                end
            end else if (blk_wait && Din_buffer_full && Ready) begin
                blk_wait <= 1'b0;
            end

            // emit is never set in S_LAST/S_OUT, so these updates don't collide.
            case (state)
                S_LAST: begin
                    if (Din_buffer_full && Ready) begin
                        Last_block <= 1'b0;
                        seen_dout  <= 1'b0;
                        state      <= S_OUT;
                    end else begin
                        Last_block <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (Dout_buffer_out_valid) begin
                        seen_dout <= 1'b1;
                    end else if (seen_dout) begin
                        seen_dout <= 1'b0;
                        state     <= S_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_padder.sv
// Self-checking bench for keccak_padder: random message data against a
// byte-level pad10*1 reference, with a keccak_buffer sink model.
module tb_keccak_padder;
    import keccak_padder_pkg::*;

    localparam int N   = IN_BUF_SIZE / 8;
    localparam int W   = RATE_BITS / IN_BUF_SIZE;
    localparam int BCW = $clog2(N) + 1;

    logic                   Clock = 1'b0;
    logic                   Reset_n;
    logic [IN_BUF_SIZE-1:0] In_data;
    logic                   In_valid;
    logic                   In_last;
    logic [BCW-1:0]         In_bytes;
    logic                   In_ready;
    logic [IN_BUF_SIZE-1:0] Din_buffer_in;
    logic                   Din_buffer_in_valid;
    logic                   Din_buffer_full;
    logic                   Ready;
    logic                   Last_block;
    logic                   Dout_buffer_out_valid;

    keccak_padder dut (
        .Clock                 (Clock),
        .Reset_n               (Reset_n),
        .In_data               (In_data),
        .In_valid              (In_valid),
        .In_last               (In_last),
        .In_bytes              (In_bytes),
        .In_ready              (In_ready),
        .Din_buffer_in         (Din_buffer_in),
        .Din_buffer_in_valid   (Din_buffer_in_valid),
        .Din_buffer_full       (Din_buffer_full),
        .Ready                 (Ready),
        .Last_block            (Last_block),
        .Dout_buffer_out_valid (Dout_buffer_out_valid)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Sink state, owned by the sink process (negedge); main touches it only at posedge+1.
    logic [63:0] got_q[$];
    bit          lb_q[$];
    int          blk_words;
    int          rdy_cnt;
    int          dig_cnt;
    bit          lb_fall;
    bit          msg_done;

    logic [7:0]  msg_q[$];

    initial begin
        Din_buffer_full       = 1'b0;
        Ready                 = 1'b0;
        Dout_buffer_out_valid = 1'b0;
        blk_words = 0; rdy_cnt = 0; dig_cnt = 0; lb_fall = 0; msg_done = 0;
        forever begin
            @(negedge Clock);
            if (!Reset_n) begin
                Din_buffer_full = 1'b0; Ready = 1'b0; Dout_buffer_out_valid = 1'b0;
                blk_words = 0; rdy_cnt = 0; dig_cnt = 0; lb_fall = 0;
                got_q.delete(); lb_q.delete();
            end else begin
                if (Din_buffer_full) check("emit_while_full", 64'(Din_buffer_in_valid), 64'd0);
                if (Din_buffer_full && !Ready) check("in_ready_blk", 64'(In_ready), 64'd0);
                if (lb_fall) begin
                    check("last_block_fall", 64'(Last_block), 64'd0);
                    lb_fall = 0;
                end
                if (dig_cnt > 0) begin
                    dig_cnt++;
                    Dout_buffer_out_valid = (dig_cnt >= 5 && dig_cnt <= 8);
                    if (dig_cnt == 11) begin
                        msg_done = 1;
                        dig_cnt  = 0;
                    end
                end
                if (Ready) begin
                    Ready = 1'b0;
                    Din_buffer_full = 1'b0;
                end else if (Din_buffer_full) begin
                    rdy_cnt--;
                    if (rdy_cnt == 0) begin
                        Ready = 1'b1;
                        lb_q.push_back(Last_block);
                        if (Last_block) begin
                            dig_cnt = 1;
                            lb_fall = 1;
                        end
                    end
                end
                if (Din_buffer_in_valid) begin
                    got_q.push_back(Din_buffer_in);
                    blk_words++;
                    if (blk_words == W) begin
                        blk_words = 0;
                        Din_buffer_full = 1'b1;
                        rdy_cnt = 3;
                        check("in_ready_after_blk", 64'(In_ready), 64'd0);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic send_word(input string tag, input logic [63:0] d, input bit last, input logic [BCW-1:0] nb);
        bit acc;
        In_data  = d;
        In_valid = 1'b1;
        In_last  = last;
        In_bytes = nb;
        acc = 0;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge Clock);
            acc = In_ready;
            step();
        end
        if (!acc) check($sformatf("%s_accept_timeout", tag), 64'd0, 64'd1);
        In_valid = 1'b0;
        In_last  = 1'b0;
    endtask

    task automatic run_msg(input string tag);
        int         len;
        int         nw;
        int         tot;
        int         nblk;
        int         nb;
        logic [7:0] pb[$];
        logic [63:0] d;
        logic [63:0] ew;
        got_q.delete();
        lb_q.delete();
        msg_done = 0;
        len  = msg_q.size();
        nw   = (len == 0) ? 1 : (len + N - 1) / N;
        tot  = ((len + 1 + RATE_BYTES - 1) / RATE_BYTES) * RATE_BYTES;
        nblk = tot / RATE_BYTES;
        for (int i = 0; i < tot; i++) pb.push_back((i < len) ? msg_q[i] : 8'h00);
        pb[len]   = pb[len] | PAD_FIRST;
        pb[tot-1] = pb[tot-1] | PAD_LAST;

        for (int w = 0; w < nw; w++) begin
            d  = {$urandom, $urandom};
            nb = (w == nw - 1) ? len - w * N : N;
            for (int k = 0; k < nb; k++) d[8*k +: 8] = msg_q[w*N + k];
            if (w != nw - 1)
                send_word(tag, d, 1'b0, BCW'($urandom));
            else if (nb == N)
                send_word(tag, d, 1'b1, BCW'($urandom_range(2**BCW - 1, N)));
            else
                send_word(tag, d, 1'b1, BCW'(nb));
        end

        for (int t = 0; t < 3000 && !msg_done; t++) step();
        check($sformatf("%s_done", tag), 64'(msg_done), 64'd1);
        check($sformatf("%s_nwords", tag), 64'(got_q.size()), 64'(tot / N));
        for (int i = 0; i < tot / N && i < got_q.size(); i++) begin
            for (int k = 0; k < N; k++) ew[8*k +: 8] = pb[i*N + k];
            check($sformatf("%s_w%0d", tag, i), got_q[i], ew);
        end
        check($sformatf("%s_nblk", tag), 64'(lb_q.size()), 64'(nblk));
        for (int i = 0; i < nblk && i < lb_q.size(); i++)
            check($sformatf("%s_lb%0d", tag, i), 64'(lb_q[i]), 64'(i == nblk - 1));
        @(negedge Clock);
        check($sformatf("%s_idle_ready", tag), 64'(In_ready), 64'd1);
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n  = 1'b0;
        In_data  = '0;
        In_valid = 1'b0;
        In_last  = 1'b0;
        In_bytes = '0;
        repeat (3) step();
        @(negedge Clock);
        check("rst_din", Din_buffer_in, 64'd0);
        check("rst_valid", 64'(Din_buffer_in_valid), 64'd0);
        check("rst_last_block", 64'(Last_block), 64'd0);
        check("rst_in_ready", 64'(In_ready), 64'd0);
        step();
        Reset_n = 1'b1;
        step();
        @(negedge Clock);
        check("post_rst_ready", 64'(In_ready), 64'd1);
        step();

        msg_q.delete();
        run_msg("empty");

        msg_q.delete();
        msg_q.push_back(8'hAA); msg_q.push_back(8'hBB); msg_q.push_back(8'hCC);
        run_msg("abc");

        msg_q.delete();
        for (int i = 0; i < 127; i++) msg_q.push_back(8'($urandom));
        run_msg("len127");

        msg_q.delete();
        for (int i = 0; i < 128; i++) msg_q.push_back(8'($urandom));
        run_msg("len128");

        for (int r = 0; r < 4; r++) begin
            msg_q.delete();
            for (int i = 0; i < $urandom_range(300, 1); i++) msg_q.push_back(8'($urandom));
            run_msg($sformatf("rand%0d", r));
        end

        // Reset after five words of an unfinished message.
        for (int w = 0; w < 5; w++) send_word("rst_mid", {$urandom, $urandom}, 1'b0, '0);
        Reset_n = 1'b0;
        step();
        @(negedge Clock);
        check("mid_rst_din", Din_buffer_in, 64'd0);
        check("mid_rst_valid", 64'(Din_buffer_in_valid), 64'd0);
        check("mid_rst_last_block", 64'(Last_block), 64'd0);
        check("mid_rst_in_ready", 64'(In_ready), 64'd0);
        step();
        Reset_n = 1'b1;
        step();

        msg_q.delete();
        msg_q.push_back(8'($urandom));
        run_msg("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
